// File: rtl/rd_port_scheduler.sv
// -----------------------------------------------------------------------------
// rd_port_scheduler
//
// Shares the read port of an asynchronous FIFO among NREQ consumers on the
// read-clock side. A round-robin arbiter hands the port to one consumer at a
// time. The owner then gets a burst of at most BURST reads. Every word coming
// back from the FIFO memory is tagged with the ID of the consumer whose read
// strobe fetched it.
//
// Ports
//   rclk_i       read-domain clock, rising edge
//   rrst_n_i     asynchronous active-low reset
//   req_i        per-consumer request (consumer wants a word and will take it)
//   empty_i      FIFO empty flag from the read handler
//   rdata_i      FIFO memory read data, valid the cycle after r_en_o
//   r_en_o       read strobe to the FIFO read handler
//   grant_o      registered one-hot current owner, zero when idle
//   busy_o       high while a burst is in progress
//   out_valid_o  returned word valid this cycle
//   out_id_o     consumer index of the returned word
//   out_data_o   returned word (held together with out_id_o while not valid)
// -----------------------------------------------------------------------------
module rd_port_scheduler #(
   parameter int NREQ       = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 8,
   parameter int BURST      = 4
) (
   input  logic                  rclk_i,
   input  logic                  rrst_n_i,
   input  logic [NREQ-1:0]       req_i,
   input  logic                  empty_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  r_en_o,
   output logic [NREQ-1:0]       grant_o,
   output logic                  busy_o,
   output logic                  out_valid_o,
   output logic [ID_WIDTH-1:0]   out_id_o,
   output logic [DATA_WIDTH-1:0] out_data_o
);

   localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ID_WIDTH-1:0]   g_q, g_d;
   logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NREQ-1:0]       grant_q, grant_d;

   // Return pipeline
   logic                  s1_en_q;
   logic [ID_WIDTH-1:0]   s1_id_q;
   logic                  out_valid_q;
   logic [ID_WIDTH-1:0]   out_id_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   // ---------------------------------------------------------------------------
   // Round-robin pick. Requests at or above ptr win first ("ahead"). If none
   // is there, the scan wraps and takes the lowest requester overall. Each
   // vector gets a lowest-set-bit one-hot, and that one-hot is encoded into
   // an index.
   // ---------------------------------------------------------------------------
   logic [NREQ-1:0]     ahead;
   logic [NREQ-1:0]     first_hi;
   logic [NREQ-1:0]     first_lo;
   logic [NREQ-1:0]     sel_oh;
   logic [ID_WIDTH-1:0] pick;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
      assign ahead[gi] = req_i[gi] && (ID_WIDTH'(gi) >= ptr_q);
      if (gi == 0) begin : g_first
         assign first_hi[gi] = ahead[gi];
         assign first_lo[gi] = req_i[gi];
      end else begin : g_rest
         assign first_hi[gi] = ahead[gi] && !(|ahead[gi-1:0]);
         assign first_lo[gi] = req_i[gi] && !(|req_i[gi-1:0]);
      end
   end

   assign sel_oh = (|ahead) ? first_hi : first_lo;

   for (genvar gb = 0; gb < ID_WIDTH; gb++) begin : g_enc
      logic [NREQ-1:0] mask;
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
         assign mask[gi] = (((gi >> gb) & 1) == 1);
      end
      assign pick[gb] = |(sel_oh & mask);
   end

   // ---------------------------------------------------------------------------
   // Burst control
   // ---------------------------------------------------------------------------
   logic                own_req;
   logic                r_en;
   logic                burst_exit;
   logic [ID_WIDTH-1:0] ptr_inc;

   // grant_q is one-hot on the owner, so this is req[g] without a variable index
   assign own_req = |(req_i & grant_q);
   assign r_en    = (state_q == ST_BURST) && own_req && !empty_i;

   // The burst ends after the last allowed read, when the owner stops asking,
   // or when the FIFO runs dry. The burst is never restarted in place; the
   // next burst goes through IDLE again.
   assign burst_exit = (r_en && (cnt_q == CNT_W'(BURST - 1))) || !own_req || empty_i;

   assign ptr_inc = (g_q == ID_WIDTH'(NREQ - 1)) ? '0 : g_q + 1'b1;

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if ((|req_i) && !empty_i) begin
               state_d = ST_BURST;
               g_d     = pick;
               grant_d = sel_oh;
               cnt_d   = '0;
            end
         end
         default: begin
            if (r_en) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (burst_exit) begin
               state_d = ST_IDLE;
               grant_d = '0;
               cnt_d   = '0;
               ptr_d   = ptr_inc;
            end
         end
      endcase
   end

   always_ff @(posedge rclk_i or negedge rrst_n_i) begin
      if (!rrst_n_i) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Return path. The ID travels alongside the strobe. Words still in flight
   // therefore keep the tag of the consumer that fetched them, even after
   // ownership moves on. out_id/out_data only update when a word arrives.
   // ---------------------------------------------------------------------------
   always_ff @(posedge rclk_i or negedge rrst_n_i) begin
      if (!rrst_n_i) begin
         s1_en_q     <= 1'b0;
         s1_id_q     <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_data_q  <= '0;
      end else begin
         s1_en_q     <= r_en;
         s1_id_q     <= g_q;
         out_valid_q <= s1_en_q;
         if (s1_en_q) begin
            out_id_q   <= s1_id_q;
            out_data_q <= rdata_i;
         end
      end
   end

   assign r_en_o      = r_en;
   assign grant_o     = grant_q;
   assign busy_o      = (state_q == ST_BURST);
   assign out_valid_o = out_valid_q;
   assign out_id_o    = out_id_q;
   assign out_data_o  = out_data_q;

endmodule

// File: doc/rd_port_scheduler.md
# rd_port_scheduler

Round-robin scheduler that shares the read port of the asynchronous FIFO among NREQ consumers on the read-clock side. It watches the read handler's `empty` flag and each consumer's request, then drives the single `r_en` strobe in bounded bursts. Each returned word is tagged with the ID of the consumer it belongs to. It sits between the FIFO read handler/memory and the downstream consumers, entirely in the `rclk` domain.

## Interface
- `NREQ`, 4, number of consumers (≥2)
- `ID_WIDTH`, 2, width of consumer ID; must equal clog2(NREQ)
- `DATA_WIDTH`, 8, FIFO word width
- `BURST`, 4, max reads per grant (≥1)

- `rclk`  in  1  read-domain clock, rising edge
- `rrst_n`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  bit i high: consumer i wants a word and will accept it
- `empty`  in  1  FIFO empty flag from read handler
- `rdata`  in  DATA_WIDTH  FIFO memory read data, valid the cycle after `r_en`
- `r_en`  out  1  read strobe to FIFO read handler
- `grant`  out  NREQ  registered one-hot current owner; all zero when idle
- `busy`  out  1  high while in BURST state
- `out_valid`  out  1  returned word valid this cycle
- `out_id`  out  ID_WIDTH  consumer index of returned word
- `out_data`  out  DATA_WIDTH  returned word

## Operation
- FSM states: IDLE, BURST. Internal: owner index `g`, round-robin pointer `ptr` (reset 0), burst counter `cnt` (0..BURST-1).
- IDLE: `grant`=0, `r_en`=0. If (|req) && !empty, select the first i with req[i]=1 scanning ptr, ptr+1, … mod NREQ; next cycle: state BURST, `g`=i, `grant`=one-hot(i), `cnt`=0. Otherwise stay.
- BURST: `r_en` = req[g] && !empty (combinational from registered `g`). Each cycle with `r_en`=1 increments `cnt`.
- BURST exit to IDLE at end of cycle if any: (`r_en` && `cnt`==BURST-1), !req[g], empty. On exit `ptr` <= (g+1) mod NREQ; `grant` clears next cycle.
- Always one IDLE cycle between bursts (arbitration bubble); owner is never preempted mid-burst.
- `r_en` is never high while `empty`=1 (no underflow) and never high in IDLE.
- Return path: 2-stage pipeline. Stage 1 registers `r_en`,`g`; stage 2 registers `out_valid`=stage-1 enable, `out_id`=stage-1 ID, `out_data`=`rdata`. When `out_valid`=0, `out_data`/`out_id` hold last value.
- Return pipeline keeps draining after the owner changes; words always carry the ID of the consumer whose `r_en` fetched them.
- Reset (asserted anytime, incl. mid-burst): immediately IDLE, `r_en`=0, `grant`=0, `busy`=0, `out_valid`=0, `out_id`=0, `out_data`=0, `ptr`=0, `cnt`=0; in-flight words discarded.
- Release: first arbitration on the first `rclk` edge after `rrst_n` deasserts.

## Timing
- Arbitration: req/!empty sampled at edge N → `grant`/`busy` high and first possible `r_en` in cycle N+1.
- Read latency: `r_en` in cycle T → `rdata` valid T+1 → `out_valid`/`out_data` in T+2.
- Back-to-back reads: one word per cycle while req[g] && !empty, up to BURST.
- Max grant length BURST cycles of `r_en`; min one cycle of `busy` even if `empty` rises immediately (zero reads).
- `empty` dropping low mid-BURST without exit condition being hit is impossible (exit is taken at the empty cycle); re-entry via IDLE.
- `ptr` wraps NREQ-1 → 0.

## Test plan
- Single consumer: req=0001, 6 words in FIFO → `r_en` high 4 cycles (cycles 1–4), IDLE cycle 5, regrant consumer 0 cycle 6, 2 more reads; 6 `out_valid` pulses, `out_id`=0, data in FIFO order, each 2 cycles after its `r_en`.
- Round-robin: req=1111, 16 words, BURST=4 → grants 0,1,2,3 in order, 4 reads each, one bubble between; `out_id` sequence 0×4,1×4,2×4,3×4.
- Empty mid-burst: req=0010, 2 words → 2 `r_en`, `empty` rises, `r_en` low that cycle, IDLE next; no read while empty; 2 `out_valid`, `out_id`=1.
- Requester drops: consumer 2 owner, req[2] falls after 1 read → exit, next grant to consumer 3 if requesting (ptr=3); word in flight still delivered with `out_id`=2.
- Pointer wrap: last owner 3, req=1001 → next grant consumer 0, then consumer 3.
- Reset mid-burst: assert `rrst_n`=0 async during 2nd read → `r_en`,`grant`,`busy`,`out_valid` go 0 without clock edge; after release with req=0100 → grant consumer 2 (ptr=0 scan).
